approx_adder_error_monitor: RTL

- Self-contained, synthesizable error-characterisation engine for the approximate adder/subtractor family (ACA, GDA, GeAr, LOA variants).
- Generates pseudo-random operand pairs and drives the DUT under test.
- Computes the exact result internally and accumulates the error statistics: sum of absolute error, maximum error, and count of erroneous results.
- Sits beside the DUT in FPGA or physical-integration test wrappers; the host divides err_sum by the vector count to obtain mean error.

---
 rtl/approx_adder_error_monitor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/approx_adder_error_monitor.sv
// Error-characterisation engine for approximate adders/subtractors: drives LFSR operand
// pairs into an external DUT, compares its result with the exact one, accumulates statistics.
module approx_adder_error_monitor #(
   parameter int          W      = 13,
   parameter int          CNT_W  = 18,
   parameter int          ACC_W  = 40,
   parameter logic [31:0] SEED_A = 32'h1,
   parameter logic [31:0] SEED_B = 32'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             add_sub,
   input  logic [CNT_W-1:0] num_vectors,
   output logic [W-1:0]     op_a,
   output logic [W-1:0]     op_b,
   output logic             op_add_sub,
   input  logic [W:0]       approx_res,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] err_sum,
   output logic [W:0]       err_max,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [31:0] LFSR_MASK = 32'h80200003;
   localparam int          SUM_W     = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_next;
   logic             start_run, load;
   logic [CNT_W-1:0] num_lat, load_cnt;
   logic             drain_cnt;
   logic [31:0]      lfsr_a, lfsr_b, src_a, src_b;
   logic             vec_valid, s1_valid;
   logic [W:0]       s1_err, exact, abs_err;
   logic [W+1:0]     ap_x, ex_x, diff, diff_neg;
   logic [SUM_W-1:0] sum_wide;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every variable driven here gets a default first, so no latch can be inferred.
   always_comb begin
      state_next = state;
      start_run  = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               start_run = 1'b1;
               if (num_vectors == '0) begin
                  state_next = DONE;
               end else begin
                  load       = 1'b1;
                  state_next = (num_vectors == CNT_W'(1)) ? DRAIN : RUN;
               end
            end
         end
         RUN: begin
            load = 1'b1;
            if (load_cnt == num_lat - CNT_W'(1)) state_next = DRAIN;
         end
         DRAIN:   if (drain_cnt) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   // The first vector of a run comes straight from the seeds.
   assign src_a = start_run ? SEED_A : lfsr_a;
   assign src_b = start_run ? SEED_B : lfsr_b;

   // Subtract mode compares signed W+1-bit values; add mode compares unsigned ones.
   always_comb begin
      exact    = op_add_sub ? ({1'b0, op_a} - {1'b0, op_b}) : ({1'b0, op_a} + {1'b0, op_b});
      ap_x     = op_add_sub ? {approx_res[W], approx_res} : {1'b0, approx_res};
      ex_x     = op_add_sub ? {exact[W], exact} : {1'b0, exact};
      diff     = ap_x - ex_x;
      diff_neg = -diff;
      abs_err  = diff[W+1] ? diff_neg[W:0] : diff[W:0];
      sum_wide = {1'b0, err_sum} + SUM_W'(s1_err);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a       <= '0;
         op_b       <= '0;
         op_add_sub <= 1'b0;
         num_lat    <= '0;
         load_cnt   <= '0;
         drain_cnt  <= 1'b0;
         lfsr_a     <= SEED_A;
         lfsr_b     <= SEED_B;
         vec_valid  <= 1'b0;
         s1_valid   <= 1'b0;
         s1_err     <= '0;
         err_sum    <= '0;
         err_max    <= '0;
         err_cnt    <= '0;
      end else begin
         vec_valid <= load;
         s1_valid  <= vec_valid;
         s1_err    <= abs_err;
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;

         if (load) begin
            op_a   <= src_a[W-1:0];
            op_b   <= src_b[W-1:0];
            lfsr_a <= lfsr_step(src_a);
            lfsr_b <= lfsr_step(src_b);
         end else if (start_run) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
         end

         if (start_run) begin
            op_add_sub <= add_sub;
            num_lat    <= num_vectors;
            load_cnt   <= CNT_W'(1);
            err_sum    <= '0;
            err_max    <= '0;
            err_cnt    <= '0;
         end else begin
            if (load) load_cnt <= load_cnt + CNT_W'(1);
            if (s1_valid) begin
               // Carry out of the widened sum means saturate rather than wrap.
               err_sum <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
               if (s1_err > err_max) err_max <= s1_err;
               if (s1_err != '0) err_cnt <= err_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
